mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
`timescale 1ns/1ps
// MEM-stage load/store unit: issues one data-memory request per aligned access,
// stalls upstream until the acknowledge arrives or a timeout aborts the request.
module mem_access #(
  parameter int         TIMEOUT = 255,
  parameter logic [3:0] OP_NOP  = 4'd0,
  parameter logic [3:0] OP_LB   = 4'd1,
  parameter logic [3:0] OP_LBU  = 4'd2,
  parameter logic [3:0] OP_LH   = 4'd3,
  parameter logic [3:0] OP_LHU  = 4'd4,
  parameter logic [3:0] OP_LW   = 4'd5,
  parameter logic [3:0] OP_SB   = 4'd6,
  parameter logic [3:0] OP_SH   = 4'd7,
  parameter logic [3:0] OP_SW   = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_pc,
  input  logic [3:0]  mem_mem_op,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_mem_data,
  input  logic        mem_we,
  input  logic [4:0]  mem_write_reg,
  input  logic [31:0] mem_write_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] wb_pc,
  output logic        wb_we,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data,
  output logic        stall_req,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          post_rst;

  logic [3:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [31:0]   pc_q;
  logic          we_q;
  logic [4:0]    rd_q;

  logic          in_mem;
  logic          in_aligned;
  logic          accept;
  logic          timeout_hit;
  logic          req_active;
  logic          store_q;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  function automatic logic op_is_mem(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_aligned(input logic [3:0] op, input logic [1:0] lsb);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1'b1;
      OP_LH, OP_LHU, OP_SH: return ~lsb[0];
      OP_LW, OP_SW:         return lsb == 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  assign in_mem      = op_is_mem(mem_mem_op);
  assign in_aligned  = op_is_aligned(mem_mem_op, mem_mem_addr[1:0]);
  assign store_q     = op_is_store(op_q);

  // The first cycle after reset accepts nothing, so stall_req stays low there.
  assign accept      = (state == IDLE) && !post_rst && in_mem && in_aligned;
  assign timeout_hit = (state == BUSY) && (cnt == CW'(TIMEOUT));
  assign req_active  = !rst && (state == BUSY) && !timeout_hit;

  assign stall_req   = !rst && (accept || ((state == BUSY) && !timeout_hit && !dm_ack));

  assign dm_req      = req_active;
  assign dm_we       = req_active && store_q;
  assign dm_addr     = req_active ? {addr_q[31:2], 2'b00} : 32'h0;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = 32'h0;
    if (req_active) begin
      case (op_q)
        OP_SB: begin
          dm_be    = 4'b0001 << addr_q[1:0];
          dm_wdata = {4{data_q[7:0]}};
        end
        OP_SH: begin
          dm_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          dm_wdata = {2{data_q[15:0]}};
        end
        default: begin
          dm_be    = 4'b1111;
          dm_wdata = data_q;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = dm_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = dm_rdata[15:8];
      2'd2:    byte_sel = dm_rdata[23:16];
      2'd3:    byte_sel = dm_rdata[31:24];
      default: byte_sel = dm_rdata[7:0];
    endcase
    half_sel = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = dm_rdata;
    endcase
  end

  // NOTE: the latched operands have no reset; they are read only while BUSY,
  // and reset forces IDLE, so their contents after reset never matter.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= mem_mem_op;
      addr_q <= mem_mem_addr;
      data_q <= mem_mem_data;
      pc_q   <= mem_pc;
      we_q   <= mem_we;
      rd_q   <= mem_write_reg;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      post_rst      <= 1'b1;
      wb_pc         <= 32'h0;
      wb_we         <= 1'b0;
      wb_write_reg  <= 5'h0;
      wb_write_data <= 32'h0;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      post_rst <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (post_rst) begin
            wb_we <= 1'b0;
          end else if (!in_mem) begin
            wb_pc         <= mem_pc;
            wb_we         <= mem_we;
            wb_write_reg  <= mem_write_reg;
            wb_write_data <= mem_write_data;
          end else if (in_aligned) begin
            state <= BUSY;
            cnt   <= '0;
            wb_we <= 1'b0;
          end else begin
            wb_we    <= 1'b0;
            misalign <= 1'b1;
          end
        end
        BUSY: begin
          if (timeout_hit) begin
            state   <= IDLE;
            wb_we   <= 1'b0;
            bus_err <= 1'b1;
          end else if (dm_ack) begin
            state        <= IDLE;
            wb_pc        <= pc_q;
            wb_write_reg <= rd_q;
            if (store_q) begin
              wb_we <= 1'b0;
            end else begin
              wb_we         <= we_q;
              wb_write_data <= load_data;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
